// File: rtl/ram_burst_reader_if.sv
// Command/status, RAM read port and output stream of ram_burst_reader.
// master = burst reader side, slave = command issuer / RAM / stream sink side.
interface ram_burst_reader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  ram_wea;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0] ram_doutb;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  start, base_addr, len, ram_wea, ram_doutb, m_ready,
        output busy, done, ram_addrb, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, len, ram_wea, ram_doutb, m_ready,
        input  busy, done, ram_addrb, m_data, m_valid, m_last
    );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst reader for the simple dual-port block RAM: issues reads, hides latency in a 4-entry FIFO.
// Optional running sum of streamed words via `define RAM_RD_CHECKSUM_EN (adds port sum_out).
module ram_burst_reader #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DEEP_LENGTH = 1024
) (
    input  logic                  clk,
    input  logic                  rstn,
`ifdef RAM_RD_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] sum_out,
`endif
    ram_burst_reader_if.master    bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [ADDR_WIDTH:0]   LenOne  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrTop = ADDR_WIDTH'(DEEP_LENGTH - 1);

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_issued;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [4];
    logic [3:0]            r_fifo_last;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic                  r_busy;
    logic                  r_done;
`ifdef RAM_RD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif

    logic [2:0]            w_occ;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pop;
    logic                  w_pop_last;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    always_comb begin
        // FIFO entries plus the read still in the RAM pipeline; capped at 3 so 4 slots never overflow
        w_occ        = r_count + {2'b00, r_inflight};
        w_issue      = (r_state == StRun) && (r_issued < r_len) && !bus.ram_wea && (w_occ < 3'd3);
        w_last_issue = w_issue && (r_issued == (r_len - LenOne));
        w_pop        = (r_count != 3'd0) && bus.m_ready;
        w_pop_last   = w_pop && r_fifo_last[r_rd_ptr];
        w_next_addr  = (r_addr == AddrTop) ? '0 : r_addr + AddrOne;
    end

    assign bus.m_valid   = (r_count != 3'd0);
    assign bus.m_data    = r_fifo_data[r_rd_ptr];
    assign bus.m_last    = bus.m_valid & r_fifo_last[r_rd_ptr];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.ram_addrb = r_addr;
`ifdef RAM_RD_CHECKSUM_EN
    assign sum_out       = r_sum;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= StIdle;
            r_addr          <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            for (int i = 0; i < 4; i++) r_fifo_data[i] <= '0;
`ifdef RAM_RD_CHECKSUM_EN
            r_sum           <= '0;
`endif
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if (w_issue) begin
                r_addr   <= w_next_addr;
                r_issued <= r_issued + LenOne;
            end
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= bus.ram_doutb;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
`ifdef RAM_RD_CHECKSUM_EN
            if (w_pop) r_sum <= r_sum + bus.m_data;
`endif
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_addr   <= bus.base_addr;
                        r_len    <= bus.len;
                        r_issued <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= (bus.len == '0);
                        r_state  <= (bus.len == '0) ? StDone : StRun;
`ifdef RAM_RD_CHECKSUM_EN
                        r_sum    <= '0;
`endif
                    end
                end
                StRun: begin
                    if (w_pop_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else if (w_last_issue) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_pop_last) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
